// File: rtl/sfa_bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sfa_bram_arb_pkg
// Shared types and constants for the two-requester BRAM arbiter.
//   state_t       : arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   BRAM_WE_FULL  : all four byte lanes written
//   BRAM_WE_NONE  : read / idle, no byte lanes written
//   DEPTH_DEFAULT : default number of valid BRAM words
// -----------------------------------------------------------------------------
package sfa_bram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BRAM_WE_FULL  = 4'b1111;
   localparam logic [3:0] BRAM_WE_NONE  = 4'b0000;
   localparam int         DEPTH_DEFAULT = 100;

endpackage

// File: rtl/sfa_rr_arb2.sv
// -----------------------------------------------------------------------------
// sfa_rr_arb2
// Combinational 2-way round-robin grant. On a tie the requester that did not
// win last time is chosen; otherwise the single valid requester wins.
// The parent owns last_grant and updates it when a request is accepted.
//   valid[1:0]  in  request present per requester
//   last_grant  in  id of the most recently granted requester
//   gnt_any     out at least one requester is valid
//   gnt_id      out id of the winning requester (meaningful when gnt_any)
// -----------------------------------------------------------------------------
module sfa_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       gnt_any,
   output logic       gnt_id
);

   always_comb begin
      gnt_any = |valid;
      if (&valid) gnt_id = ~last_grant;
      else        gnt_id = valid[1];
   end

endmodule

// File: rtl/sfa_bram_arbiter.sv
// -----------------------------------------------------------------------------
// sfa_bram_arbiter
// Shares one single-port BRAM (1-cycle registered read) between two requesters
// with round-robin arbitration. Every op takes IDLE -> ISSUE -> WAIT -> DONE:
// accept at T, BRAM access at T+1, done pulse at T+3, next accept at T+4.
//
// Optional feature (macro SFA_BRAM_ARB_RANGE_CHECK_EN): ops whose address is
// >= DEPTH skip the BRAM access, return rdata=0 and complete with err=1.
// Without the macro the address passes through unchecked and err is 0.
//
// Ports:
//   bram_clk, bram_rstn          clock, async active-low reset
//   reqN_valid/ready             request handshake (N = 0, 1)
//   reqN_we/addr/wdata           request fields
//   reqN_rdata/done/err          completion: data, 1-cycle pulse, range error
//   bram_en/we/addr/din          BRAM port drive
//   bram_dout                    BRAM read data (registered)
// -----------------------------------------------------------------------------
module sfa_bram_arbiter
   import sfa_bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = DEPTH_DEFAULT
) (
   input  logic                  bram_clk,
   input  logic                  bram_rstn,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic [DATA_WIDTH-1:0] req0_rdata,
   output logic                  req0_done,
   output logic                  req0_err,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic [DATA_WIDTH-1:0] req1_rdata,
   output logic                  req1_done,
   output logic                  req1_err,

   output logic                  bram_en,
   output logic [3:0]            bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout
);

`ifdef SFA_BRAM_ARB_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   // one extra bit so DEPTH values near 2**ADDR_WIDTH still compare correctly
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state_q, state_d;
   logic                  last_grant_q;
   logic                  lat_we, lat_id, lat_oor;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

   logic                  gnt_any, gnt_id, accept;
   logic                  win_we, win_oor;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   sfa_rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_q),
      .gnt_any    (gnt_any),
      .gnt_id     (gnt_id)
   );

   assign win_we    = gnt_id ? req1_we    : req0_we;
   assign win_addr  = gnt_id ? req1_addr  : req0_addr;
   assign win_wdata = gnt_id ? req1_wdata : req0_wdata;
   // constant-folds to 0 when the range check is compiled out
   assign win_oor   = RANGE_CHECK & ({1'b0, win_addr} >= DEPTH_LIM);

   // next state and handshake / BRAM strobes
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      req0_done  = 1'b0;
      req1_done  = 1'b0;
      bram_en    = 1'b0;
      bram_we    = BRAM_WE_NONE;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
            // gated by reset so no handshake is shown while held in reset
            req0_ready = accept & ~gnt_id & bram_rstn;
            req1_ready = accept &  gnt_id & bram_rstn;
         end
         ISSUE: begin
            bram_en = ~lat_oor;
            if (lat_we && !lat_oor) bram_we = BRAM_WE_FULL;
            state_d = WAIT;
         end
         WAIT: begin
            state_d = DONE;
         end
         DONE: begin
            req0_done = ~lat_id;
            req1_done =  lat_id;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // address and write data come straight from the latch, so they hold
   // through WAIT and clear to 0 on reset
   assign bram_addr  = lat_addr;
   assign bram_din   = lat_wdata;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;

`ifdef SFA_BRAM_ARB_RANGE_CHECK_EN
   assign req0_err = req0_done & lat_oor;
   assign req1_err = req1_done & lat_oor;
`else
   assign req0_err = 1'b0;
   assign req1_err = 1'b0;
`endif

   always_ff @(posedge bram_clk or negedge bram_rstn) begin
      if (!bram_rstn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;          // req0 wins the first tie
         lat_we       <= 1'b0;
         lat_id       <= 1'b0;
         lat_oor      <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            lat_we       <= win_we;
            lat_id       <= gnt_id;
            lat_oor      <= win_oor;
            lat_addr     <= win_addr;
            lat_wdata    <= win_wdata;
            last_grant_q <= gnt_id;
         end
         // BRAM output is valid in WAIT (one cycle after the ISSUE strobe)
         if (state_q == WAIT && !lat_we) begin
            if (lat_id) rdata1_q <= lat_oor ? '0 : bram_dout;
            else        rdata0_q <= lat_oor ? '0 : bram_dout;
         end
      end
   end

endmodule

// File: doc/sfa_bram_arbiter.md
Name: sfa_bram_arbiter

Overview:
Two-requester round-robin arbiter that shares one single-port sfa_bram instance between two processing elements of the 2x2 array.
- Accepts read/write requests on valid/ready handshakes and drives the BRAM port one access at a time.
- Captures read data and returns a one-cycle done pulse to the owning requester.
- Sits between the PE memory interfaces and the BRAM.

Parameters:
- ADDR_WIDTH, 32, width of requester and BRAM address.
- DATA_WIDTH, 32, width of read/write data.
- DEPTH, 100, number of valid BRAM words; used by the optional range check.

Ports:
- bram_clk  in  1  single clock for arbiter and BRAM.
- bram_rstn  in  1  asynchronous active-low reset.
- reqN_valid  in  1  request N present (N = 0, 1).
- reqN_ready  out  1  request N accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_rdata  out  DATA_WIDTH  read data; valid when reqN_done is high.
- reqN_done  out  1  one-cycle completion pulse, for reads and writes.
- reqN_err  out  1  range error flag, qualified by reqN_done.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_dout  in  DATA_WIDTH  BRAM read data; registered, 1-cycle latency.

Behaviour:
- Reset (bram_rstn=0, asynchronous): all outputs 0, FSM in IDLE, last_grant=1 so req0 wins the first tie, latched request cleared. Reset mid-operation aborts the access; no done pulse is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Every op, read or write, takes the same path.
- IDLE:
  - If any valid is high, select a winner: the only valid requester, or on a tie the requester not equal to last_grant.
  - reqW_ready=1 combinationally in that same cycle.
  - Latch we/addr/wdata and the winner id; update last_grant; go to ISSUE.
  - Ready is never asserted outside IDLE.
- ISSUE (1 cycle):
  - bram_en=1, bram_addr=latched addr.
  - Write: bram_we=4'b1111, bram_din=latched data.
  - Read: bram_we=0.
  - Next state WAIT.
- WAIT (1 cycle):
  - bram_en=0, bram_we=0, bram_addr/bram_din hold.
  - Read: capture bram_dout into the winner's rdata register.
  - Write: rdata unchanged.
- DONE (1 cycle): reqW_done=1 for exactly one cycle; next state IDLE.
- Latency and throughput: accept at cycle T, BRAM access at T+1, done at T+3. Next accept no earlier than T+4.
- Requester rules:
  - Request fields must be stable while valid=1 and ready=0.
  - Deasserting valid before ready is legal; no access occurs.
  - A requester may hold valid high across its own done; it re-arbitrates in IDLE.
- reqN_rdata holds its last captured value until the next read completion for N. The loser's outputs are untouched.
- Starvation bound: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- reqN_err is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: SFA_BRAM_ARB_RANGE_CHECK_EN.
- Enabled:
  - In IDLE, a latched addr >= DEPTH marks the op as out-of-range.
  - ISSUE then keeps bram_en=0 and bram_we=0.
  - WAIT loads rdata=0.
  - DONE pulses done with err=1.
  - Latency is unchanged.
- Disabled: no check; the address passes through unchecked; reqN_err tied 0.

Decomposition:
- Package sfa_bram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - BRAM_WE_FULL = 4'b1111, BRAM_WE_NONE = 4'b0000;
  - DEPTH_DEFAULT = 100.
- Sub-module sfa_rr_arb2:
  - combinational 2-way round-robin grant from valid[1:0] and last_grant;
  - last_grant update performed in the parent on accept.

Test Plan:
- Single read: req0 read addr 5, BRAM preloaded with 0x0000_0001 at addr 5 -> ready at T, bram_en at T+1, req0_done at T+3 with req0_rdata=0x0000_0001.
- Write then read: req1 writes 0xDEAD_BEEF to addr 10, then reads addr 10 -> bram_we=4'b1111 for exactly one cycle; read done returns 0xDEAD_BEEF.
- Tie after reset: both valid, req0 read addr 0, req1 read addr 4 -> req0 granted first, req1 accepted 4 cycles later. Grants alternate 0,1,0,1 over 8 back-to-back ops.
- Mid-op reset: assert bram_rstn=0 during WAIT -> all outputs 0 immediately, no done pulse; after release, first tie grants req0.
- Withdrawn request: req1_valid high for 1 cycle while the FSM is in ISSUE, then low -> no ready, no BRAM access for req1.
- Range check (SFA_BRAM_ARB_RANGE_CHECK_EN defined): req0 read addr 100 -> bram_en stays 0, done at T+3 with err=1 and rdata=0. Without the macro, bram_en pulses at addr 100 and err=0.
